change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, coin-request buffer depth in entries (power of two, >=2).
REQ-002 SHALL have parameter STROBE_CYCLES, default 4, ejector strobe width in clock cycles (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait for i_eject_done after the strobe ends (1..255).
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_change_denomination_code  input  4  denomination to eject; codes 0-14 valid, 15 invalid.
REQ-007 SHALL have port i_change_valid  input  1  one-cycle qualifier for i_change_denomination_code.
REQ-008 SHALL have port i_no_change  input  1  vending machine cannot return change.
REQ-009 SHALL have port i_eject_done  input  1  ejector mechanism completion acknowledge.
REQ-010 SHALL have port i_fault_clr  input  1  clears the FAULT state.
REQ-011 SHALL have port o_eject_code  output  4  registered denomination being ejected.
REQ-012 SHALL have port o_eject_strobe  output  1  registered ejector fire command.
REQ-013 SHALL have port o_busy  output  1  FSM not IDLE or FIFO not empty.
REQ-014 SHALL have port o_fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-015 SHALL have port o_overflow  output  1  one-cycle pulse: request dropped because FIFO full.
REQ-016 SHALL have port o_bad_code  output  1  one-cycle pulse: code 15 received and dropped.
REQ-017 SHALL have port o_no_change_lamp  output  1  sticky no-change indicator.
REQ-018 SHALL have port o_fault  output  1  high while in FAULT.
REQ-019 SHALL have port o_coin_count  output  8  completed ejections, wraps 255->0.

Function
REQ-020 SHALL push code into FIFO on rising edge where i_change_valid=1, code<=14, and FIFO not full; push and pop in the same cycle SHALL both occur, even when FIFO full.
REQ-021 SHALL drop a valid request when FIFO full with no same-cycle pop, pulsing o_overflow for 1 cycle; code 15 SHALL never be stored and SHALL pulse o_bad_code.
REQ-022 FSM states SHALL be IDLE, STROBE, WAIT_DONE, FAULT.
REQ-023 IDLE: if FIFO not empty, pop head into o_eject_code, go STROBE; push at edge N into empty FIFO yields o_eject_strobe=1 after edge N+1.
REQ-024 STROBE: o_eject_strobe=1 for exactly STROBE_CYCLES cycles, then WAIT_DONE; i_eject_done ignored in STROBE.
REQ-025 WAIT_DONE: on i_eject_done=1 increment o_coin_count, go IDLE; next pop no earlier than following cycle.
REQ-026 o_eject_code SHALL hold stable from pop until return to IDLE.
REQ-027 o_no_change_lamp SHALL set on i_no_change=1 and clear on next accepted push; if both in same cycle, set wins.
REQ-028 FIFO contents SHALL be retained in FAULT; pushes continue to be accepted there.

Reset
REQ-029 Reset assertion SHALL asynchronously force IDLE, empty FIFO, o_eject_code=0, o_eject_strobe=0, o_busy=0, o_fifo_full=0, o_overflow=0, o_bad_code=0, o_no_change_lamp=0, o_fault=0, o_coin_count=0.
REQ-030 Reset mid-STROBE SHALL drop the strobe immediately and discard the in-flight coin without counting it.

Configuration
REQ-031 Macro CHANGE_DISPENSER_TIMEOUT_EN defined: WAIT_DONE counts cycles; reaching TIMEOUT_CYCLES without i_eject_done goes FAULT; FAULT exits to IDLE on i_fault_clr=1; o_fault=1 in FAULT.
REQ-032 Macro undefined: no timeout counter, WAIT_DONE waits indefinitely, FAULT unreachable, o_fault tied 0, i_fault_clr ignored.

Verification
REQ-033 Push code 3 into empty FIFO, done 2 cycles after strobe -> o_eject_code=3, strobe high 4 cycles, o_coin_count=1, o_busy low after.
REQ-034 Push 9 codes back-to-back with ejector stalled -> 8 accepted, o_fifo_full=1, one o_overflow pulse; ejections in push order.
REQ-035 Push code 15 -> o_bad_code pulse, no strobe, o_busy stays 0.
REQ-036 With macro, no i_eject_done -> o_fault=1 after 255 WAIT_DONE cycles; i_fault_clr -> IDLE, next queued coin strobes; without macro no fault.
REQ-037 i_no_change pulse -> lamp=1; next push code 5 -> lamp=0.
REQ-038 Assert reset during STROBE with 3 queued -> strobe low immediately, FIFO empty, o_coin_count=0.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin-change dispenser: buffers denomination requests in a FIFO and fires the ejector once per coin.
// Define CHANGE_DISPENSER_TIMEOUT_EN to enable the ejector-acknowledge timeout and the FAULT state.
module change_dispenser #(
  parameter int FIFO_DEPTH     = 8,
  parameter int STROBE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_change_denomination_code,
  input  logic       i_change_valid,
  input  logic       i_no_change,
  input  logic       i_eject_done,
  input  logic       i_fault_clr,
  output logic [3:0] o_eject_code,
  output logic       o_eject_strobe,
  output logic       o_busy,
  output logic       o_fifo_full,
  output logic       o_overflow,
  output logic       o_bad_code,
  output logic       o_no_change_lamp,
  output logic       o_fault,
  output logic [7:0] o_coin_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [3:0] BAD_CODE = 4'd15;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (STROBE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timing
    $error("STROBE_CYCLES must be >= 1 and TIMEOUT_CYCLES within 1..255");
  end

  typedef enum logic [1:0] {IDLE, STROBE, WAIT_DONE, FAULT} state_t;

  state_t        state, state_next;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   fill;
  logic          empty, full, req_ok, pop, push;
  logic [SW-1:0] strobe_cnt;
  logic          strobe_last, timeout;
  logic          strobe_d, fault_d, coin_inc;

  assign empty  = (fill == '0);
  assign full   = (fill == (AW+1)'(FIFO_DEPTH));
  assign req_ok = i_change_valid && (i_change_denomination_code != BAD_CODE);
  assign pop    = (state == IDLE) && !empty;
  // A pop frees a slot in the same edge, so a full FIFO still accepts when the head leaves.
  assign push   = req_ok && (!full || pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // NOTE: storage has no reset; the fill count alone decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_change_denomination_code;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) strobe_cnt <= '0;
    else if (state == STROBE) strobe_cnt <= strobe_cnt + SW'(1);
    else strobe_cnt <= '0;
  end
  assign strobe_last = (strobe_cnt == SW'(STROBE_CYCLES - 1));

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wait_cnt <= '0;
    else if (state == WAIT_DONE) wait_cnt <= wait_cnt + 8'd1;
    else wait_cnt <= '0;
  end
  assign timeout = (state == WAIT_DONE) && !i_eject_done && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_next;
  end

  // NOTE: default assignment first keeps this combinational block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!empty) state_next = STROBE;
      STROBE:    if (strobe_last) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (i_eject_done) state_next = IDLE;
        else if (timeout) state_next = FAULT;
      end
      FAULT:     if (i_fault_clr) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    strobe_d = (state_next == STROBE);
    fault_d  = (state_next == FAULT);
    coin_inc = (state == WAIT_DONE) && i_eject_done;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_eject_code     <= '0;
      o_eject_strobe   <= 1'b0;
      o_overflow       <= 1'b0;
      o_bad_code       <= 1'b0;
      o_no_change_lamp <= 1'b0;
      o_fault          <= 1'b0;
      o_coin_count     <= '0;
    end else begin
      if (pop) o_eject_code <= mem[rd_ptr];
      o_eject_strobe <= strobe_d;
      o_fault        <= fault_d;
      o_overflow     <= req_ok && !push;
      o_bad_code     <= i_change_valid && (i_change_denomination_code == BAD_CODE);
      if (coin_inc) o_coin_count <= o_coin_count + 8'd1;
      if (i_no_change) o_no_change_lamp <= 1'b1;
      else if (push) o_no_change_lamp <= 1'b0;
    end
  end

  assign o_busy      = (state != IDLE) || !empty;
  assign o_fifo_full = full;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a coin-lifecycle reference model.
module tb_change_dispenser;

  localparam int DEPTH  = 8;
  localparam int STROBE = 4;
  localparam int TMO    = 255;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_change_denomination_code = '0;
  logic       i_change_valid = 1'b0;
  logic       i_no_change = 1'b0;
  logic       i_eject_done = 1'b0;
  logic       i_fault_clr = 1'b0;
  logic [3:0] o_eject_code;
  logic       o_eject_strobe, o_busy, o_fifo_full, o_overflow, o_bad_code;
  logic       o_no_change_lamp, o_fault;
  logic [7:0] o_coin_count;

  change_dispenser #(
    .FIFO_DEPTH(DEPTH), .STROBE_CYCLES(STROBE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_change_denomination_code(i_change_denomination_code),
    .i_change_valid(i_change_valid), .i_no_change(i_no_change),
    .i_eject_done(i_eject_done), .i_fault_clr(i_fault_clr),
    .o_eject_code(o_eject_code), .o_eject_strobe(o_eject_strobe),
    .o_busy(o_busy), .o_fifo_full(o_fifo_full), .o_overflow(o_overflow),
    .o_bad_code(o_bad_code), .o_no_change_lamp(o_no_change_lamp),
    .o_fault(o_fault), .o_coin_count(o_coin_count)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of waiting coins plus the life of the coin currently at the ejector.
  logic [3:0] mq[$];
  logic [3:0] m_code;
  logic [7:0] m_coins;
  bit         m_active, m_fault, m_lamp, m_ovf, m_bad;
  int         m_strobe_left, m_waited;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_code = '0; m_coins = '0;
    m_active = 0; m_fault = 0; m_lamp = 0; m_ovf = 0; m_bad = 0;
    m_strobe_left = 0; m_waited = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] c, input bit nc, input bit d, input bit fc);
    bit good, pop, push;
    good = v && (c != 4'd15);
    pop  = !m_active && !m_fault && (mq.size() != 0);
    push = good && ((mq.size() < DEPTH) || pop);
    m_ovf = good && !push;
    m_bad = v && (c == 4'd15);
    if (nc) m_lamp = 1;
    else if (push) m_lamp = 0;
    if (m_fault) begin
      if (fc) m_fault = 0;
    end else if (!m_active) begin
      if (pop) begin
        m_code = mq.pop_front();
        m_active = 1;
        m_strobe_left = STROBE;
        m_waited = 0;
      end
    end else if (m_strobe_left > 0) begin
      m_strobe_left--;
    end else if (d) begin
      m_coins = m_coins + 8'd1;
      m_active = 0;
    end else begin
      m_waited++;
      if (TMO_EN && m_waited == TMO) begin
        m_active = 0;
        m_fault = 1;
      end
    end
    if (push) mq.push_back(c);
  endtask

  task automatic compare_all();
    check("eject_code", o_eject_code, m_code);
    check("eject_strobe", o_eject_strobe, m_active && m_strobe_left > 0);
    check("busy", o_busy, m_active || m_fault || mq.size() != 0);
    check("fifo_full", o_fifo_full, mq.size() == DEPTH);
    check("overflow", o_overflow, m_ovf);
    check("bad_code", o_bad_code, m_bad);
    check("no_change_lamp", o_no_change_lamp, m_lamp);
    check("fault", o_fault, m_fault);
    check("coin_count", o_coin_count, m_coins);
  endtask

  // Called at a falling edge: drive, let the rising edge happen, then compare at the next falling edge.
  task automatic cycle(input bit v, input logic [3:0] c, input bit nc, input bit d, input bit fc);
    i_change_valid = v;
    i_change_denomination_code = c;
    i_no_change = nc;
    i_eject_done = d;
    i_fault_clr = fc;
    @(posedge i_clk);
    model_step(v, c, nc, d, fc);
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic idle_cycles(input int n, input bit d);
    for (int k = 0; k < n; k++) cycle(0, 4'd0, 0, d, 0);
  endtask

  task automatic drain();
    int budget;
    budget = 400;
    while ((m_active || m_fault || mq.size() != 0) && budget > 0) begin
      cycle(0, 4'd0, 0, 1, 1);
      budget--;
    end
    if (m_active || m_fault || mq.size() != 0) check("drain_bound", 1, 0);
  endtask

  initial begin
    model_reset();
    @(negedge i_clk);
    compare_all();
    i_rst_n = 1'b1;

    // Single coin: code 3, acknowledged two cycles after the strobe ends.
    cycle(1, 4'd3, 0, 0, 0);
    idle_cycles(STROBE + 2, 0);
    cycle(0, 4'd0, 0, 1, 0);
    idle_cycles(2, 0);

    // Invalid code is dropped and flagged.
    cycle(1, 4'd15, 0, 0, 0);
    idle_cycles(2, 0);

    // No-change lamp sets, then clears on the next accepted push.
    cycle(0, 4'd0, 1, 0, 0);
    cycle(1, 4'd5, 0, 0, 0);
    drain();

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)), $urandom_range(0, 31) == 0,
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end
    drain();

    // One coin parked in WAIT_DONE, then nine requests against a stalled ejector.
    cycle(1, 4'd7, 0, 0, 0);
    idle_cycles(STROBE + 2, 0);
    for (int k = 0; k < 9; k++) cycle(1, 4'(k + 1), 0, 0, 0);
    idle_cycles(TMO + 5, 0);
    cycle(0, 4'd0, 0, 0, 1);
    idle_cycles(2, 0);
    drain();

    // Reset in the middle of a strobe with three coins queued.
    cycle(1, 4'd2, 0, 0, 0);
    cycle(1, 4'd4, 0, 0, 0);
    cycle(1, 4'd6, 0, 0, 0);
    cycle(1, 4'd8, 0, 0, 0);
    cycle(0, 4'd0, 1, 0, 0);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_strobe", o_eject_strobe, 0);
    check("rst_busy", o_busy, 0);
    check("rst_full", o_fifo_full, 0);
    check("rst_coins", o_coin_count, 0);
    check("rst_code", o_eject_code, 0);
    check("rst_lamp", o_no_change_lamp, 0);
    model_reset();
    i_rst_n = 1'b1;
    cycle(0, 4'd0, 0, 0, 0);

    // Short random run after reset.
    for (int k = 0; k < 300; k++) begin
      cycle($urandom_range(0, 9) < 5, 4'($urandom_range(0, 15)), $urandom_range(0, 31) == 0,
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
